// File: rtl/rv32_pkg.sv
// Shared RV32 register-file types: FSM state encoding and default parameter values.
// Imported by the register file top and its bypass sub-module.
package rv32_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  localparam int RV32_XLEN     = 32;
  localparam int RV32_NREGS    = 32;
  localparam int RV32_NRD      = 2;
  localparam int RV32_NWR      = 1;
  localparam int RV32_ZERO_REG = 1;

endpackage

// File: rtl/rv32_rf_bypass.sv
// Per-read-port write-first select: highest-numbered enabled write port hitting the address wins.
// Purely combinational; zero-register reads are forced to 0 regardless of same-cycle writes.
module rv32_rf_bypass
  import rv32_pkg::*;
#(
  parameter int XLEN     = RV32_XLEN,
  parameter int AW       = 5,
  parameter int NWR      = RV32_NWR,
  parameter int ZERO_REG = RV32_ZERO_REG
) (
  input  logic [AW-1:0]             rd_addr,
  input  logic [XLEN-1:0]           rf_data,
  input  logic [NWR-1:0]            wr_en,
  input  logic [NWR-1:0][AW-1:0]    wr_addr,
  input  logic [NWR-1:0][XLEN-1:0]  wr_data,
  output logic [XLEN-1:0]           rd_data
);

  always_comb begin
    rd_data = rf_data;
    // Ascending scan so a later (higher-numbered) port overrides an earlier one.
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && (wr_addr[w] == rd_addr)) begin
        rd_data = wr_data[w];
      end
    end
    if ((ZERO_REG != 0) && (rd_addr == '0)) begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/rv32_param_register_file.sv
// Parameterised multi-port register file with a one-register-per-cycle clear sweep after reset.
// Reads are registered (1-cycle latency, write-first); rf_ready gates use, there is no backpressure.
module rv32_param_register_file
  import rv32_pkg::*;
#(
  parameter int XLEN     = RV32_XLEN,
  parameter int NREGS    = RV32_NREGS,
  parameter int NRD      = RV32_NRD,
  parameter int NWR      = RV32_NWR,
  parameter int ZERO_REG = RV32_ZERO_REG,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      rf_ready,
  input  logic [NRD-1:0][AW-1:0]    rd_addr,
  output logic [NRD-1:0][XLEN-1:0]  rd_data,
  input  logic [NWR-1:0]            wr_en,
  input  logic [NWR-1:0][AW-1:0]    wr_addr,
  input  logic [NWR-1:0][XLEN-1:0]  wr_data
);

  localparam logic [AW:0] LAST_IDX = (AW+1)'(NREGS - 1);

  rf_state_e   state;
  rf_state_e   state_nxt;
  logic [AW:0] sweep_cnt;

  logic [XLEN-1:0]           mem [NREGS];
  logic [NRD-1:0][XLEN-1:0]  byp_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RF_CLEAR;
      sweep_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == RF_CLEAR) begin
        sweep_cnt <= sweep_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RF_CLEAR: if (sweep_cnt == LAST_IDX) state_nxt = RF_RUN;
      RF_RUN:   state_nxt = RF_RUN;
      default:  state_nxt = RF_CLEAR;
    endcase
  end

  assign rf_ready = (state == RF_RUN);

  // No reset on the array so it can map onto RAM; the sweep is the only clear path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == RF_CLEAR) begin
        mem[sweep_cnt[AW-1:0]] <= '0;
      end else begin
        for (int w = 0; w < NWR; w++) begin
          if (wr_en[w] && !((ZERO_REG != 0) && (wr_addr[w] == '0))) begin
            mem[wr_addr[w]] <= wr_data[w];
          end
        end
      end
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    rv32_rf_bypass #(
      .XLEN     (XLEN),
      .AW       (AW),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG)
    ) u_bypass (
      .rd_addr (rd_addr[r]),
      .rf_data (mem[rd_addr[r]]),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (byp_data[r])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || (state == RF_CLEAR)) begin
      rd_data <= '0;
    end else begin
      rd_data <= byp_data;
    end
  end

endmodule

// File: tb/tb_rv32_param_register_file.sv
// Directed bench for rv32_param_register_file (2 read ports, 2 write ports, x0 hardwired).
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.
module tb_rv32_param_register_file;

  logic             clk;
  logic             rst;
  logic             rf_ready;
  logic [1:0][4:0]  rd_addr;
  logic [1:0][31:0] rd_data;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][31:0] wr_data;

  int n_total = 0;
  int n_bad   = 0;
  int n_clr;

  rv32_param_register_file #(
    .XLEN     (32),
    .NREGS    (32),
    .NRD      (2),
    .NWR      (2),
    .ZERO_REG (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rf_ready (rf_ready),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wr();
    wr_en   = 2'b00;
    wr_addr = '0;
    wr_data = '0;
  endtask

  // Counts edges from reset release until rf_ready rises; bounded at 200.
  task automatic wait_ready(output int n);
    n = 0;
    while (!rf_ready && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic wr1(input int port, input logic [4:0] a, input logic [31:0] d);
    idle_wr();
    wr_en[port]   = 1'b1;
    wr_addr[port] = a;
    wr_data[port] = d;
    tick();
    idle_wr();
  endtask

  task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr[0] = a0;
    rd_addr[1] = a1;
    tick();
  endtask

  initial begin
    rst     = 1'b1;
    rd_addr = '0;
    idle_wr();
    tick();
    tick();
    chk("rst_ready", {31'b0, rf_ready}, 32'd0);
    chk("rst_rd0", rd_data[0], 32'h0);
    chk("rst_rd1", rd_data[1], 32'h0);

    // Reset release and full clear length
    rst = 1'b0;
    wait_ready(n_clr);
    chk("clear_len", n_clr, 32'd32);
    for (int a = 0; a < 32; a++) begin
      rd2(5'(a), 5'(31 - a));
      chk("sweep_zero_p0", rd_data[0], 32'h0);
      chk("sweep_zero_p1", rd_data[1], 32'h0);
    end

    // Basic write then read, 1-cycle latency
    wr1(0, 5'd5, 32'hDEADBEEF);
    rd2(5'd5, 5'd0);
    chk("wr_rd_x5", rd_data[0], 32'hDEADBEEF);
    rd2(5'd1, 5'd5);
    chk("rd_addr_change_p0", rd_data[0], 32'h0);
    chk("wr_rd_x5_p1", rd_data[1], 32'hDEADBEEF);

    // Write-first bypass on both ports, over an older stored value
    wr1(0, 5'd7, 32'hCAFE0007);
    rd_addr[0] = 5'd7; rd_addr[1] = 5'd7;
    wr_en[0] = 1'b1; wr_addr[0] = 5'd7; wr_data[0] = 32'h12345678;
    tick();
    idle_wr();
    chk("byp_p0", rd_data[0], 32'h12345678);
    chk("byp_p1", rd_data[1], 32'h12345678);
    rd2(5'd7, 5'd7);
    chk("byp_stored", rd_data[0], 32'h12345678);

    // Zero register ignores writes and bypass
    rd_addr[0] = 5'd0;
    wr_en[1] = 1'b1; wr_addr[1] = 5'd0; wr_data[1] = 32'hFFFFFFFF;
    tick();
    idle_wr();
    chk("x0_byp", rd_data[0], 32'h0);
    rd2(5'd0, 5'd0);
    chk("x0_later", rd_data[0], 32'h0);

    // Dual write to the same address: port 1 wins
    rd_addr[0] = 5'd3; rd_addr[1] = 5'd3;
    wr_en   = 2'b11;
    wr_addr[0] = 5'd3; wr_data[0] = 32'hAAAA0000;
    wr_addr[1] = 5'd3; wr_data[1] = 32'h5555FFFF;
    tick();
    idle_wr();
    chk("dual_byp_p0", rd_data[0], 32'h5555FFFF);
    chk("dual_byp_p1", rd_data[1], 32'h5555FFFF);
    rd2(5'd3, 5'd3);
    chk("dual_stored", rd_data[1], 32'h5555FFFF);

    // Dual write to distinct addresses: both commit
    wr_en   = 2'b11;
    wr_addr[0] = 5'd10; wr_data[0] = 32'h00000010;
    wr_addr[1] = 5'd11; wr_data[1] = 32'h00000011;
    tick();
    idle_wr();
    rd2(5'd10, 5'd11);
    chk("distinct_x10", rd_data[0], 32'h00000010);
    chk("distinct_x11", rd_data[1], 32'h00000011);

    // Reset mid-sweep at index 10, with writes attempted during the sweep
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_addr[0] = 5'd5; rd_addr[1] = 5'd5;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_ready", {31'b0, rf_ready}, 32'd0);
    chk("mid_rd", rd_data[0], 32'h0);
    wr_en[0] = 1'b1; wr_addr[0] = 5'd2; wr_data[0] = 32'h00000BAD;
    rst = 1'b1;
    tick();
    chk("mid_rst_ready", {31'b0, rf_ready}, 32'd0);
    chk("mid_rst_rd", rd_data[1], 32'h0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    idle_wr();
    wait_ready(n_clr);
    chk("resweep_len", n_clr + 3, 32'd32);
    rd2(5'd2, 5'd5);
    chk("clr_ignored_wr_x2", rd_data[0], 32'h0);
    chk("resweep_x5", rd_data[1], 32'h0);

    // Reset in RUN after traffic, held several cycles
    wr1(0, 5'd9, 32'h00000001);
    rd2(5'd9, 5'd9);
    chk("x9_set", rd_data[0], 32'h00000001);
    rst = 1'b1;
    tick();
    chk("run_rst_ready", {31'b0, rf_ready}, 32'd0);
    chk("run_rst_rd", rd_data[0], 32'h0);
    tick();
    tick();
    rst = 1'b0;
    wait_ready(n_clr);
    chk("run_rst_len", n_clr, 32'd32);
    rd2(5'd9, 5'd7);
    chk("x9_cleared", rd_data[0], 32'h0);
    chk("x7_cleared", rd_data[1], 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
